// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb
//  Description : Register file fed by the write-back stage, with two
//                combinational read ports (write-back bypass) and a
//                pending-write scoreboard that stalls decode on RAW/WAW
//                hazards the bypass cannot resolve.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   // write-back port
   input  logic              we3,
   input  logic [AW-1:0]     a3,
   input  logic [DW-1:0]     wd3,
   // decode read ports
   input  logic [AW-1:0]     a1,
   input  logic [AW-1:0]     a2,
   output logic [DW-1:0]     rd1,
   output logic [DW-1:0]     rd2,
   // decode issue interface
   input  logic              src1_used,
   input  logic              src2_used,
   input  logic              issue_valid,
   input  logic              issue_we,
   input  logic [AW-1:0]     issue_dst,
   output logic              stall,
   output logic [2**AW-1:0]  busy_vec
);

   localparam int NREG = 2**AW;

   // architectural storage and pending-write bits
   logic [DW-1:0]    r_regs [NREG];
   logic [NREG-1:0]  r_busy;

   // bypass hits and hazard terms
   logic             w_hit1;
   logic             w_hit2;
   logic             w_hit_dst;
   logic             w_raw1;
   logic             w_raw2;
   logic             w_waw;
   logic             w_accept;

   // Write-back into storage; reset clears every register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (we3) begin
         r_regs[a3] <= wd3;
      end
   end

   // Bypass comparisons and read muxes: a write in flight is seen the same cycle.
   always_comb begin
      w_hit1    = we3 && (a3 == a1);
      w_hit2    = we3 && (a3 == a2);
      w_hit_dst = we3 && (a3 == issue_dst);
      rd1       = w_hit1 ? wd3 : r_regs[a1];
      rd2       = w_hit2 ? wd3 : r_regs[a2];
   end

   // Hazard detection; a hazard covered by this cycle's write-back is masked.
   always_comb begin
      w_raw1   = src1_used && r_busy[a1] && !w_hit1;
      w_raw2   = src2_used && r_busy[a2] && !w_hit2;
      w_waw    = issue_we && r_busy[issue_dst] && !w_hit_dst;
      stall    = issue_valid && (w_raw1 || w_raw2 || w_waw);
      w_accept = issue_valid && !stall;
   end

   // One scoreboard bit per register. A same-edge set from a newly accepted
   // instruction beats the clear from write-back: the issuer is younger and
   // its write is still outstanding.
   generate
      for (genvar g = 0; g < NREG; g++) begin : g_busy
         logic w_set;
         logic w_clr;

         // set/clear qualifiers for this register
         always_comb begin
            w_set = w_accept && issue_we && (issue_dst == AW'(g));
            w_clr = we3 && (a3 == AW'(g));
         end

         // pending-write flag, set wins over clear
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_busy[g] <= 1'b0;
            end else if (w_set) begin
               r_busy[g] <= 1'b1;
            end else if (w_clr) begin
               r_busy[g] <= 1'b0;
            end
         end
      end
   endgenerate

   assign busy_vec = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb
//  Description : Directed scoreboard bench for regfile_wb. The driver applies
//                a vector just after a rising edge and queues the expected
//                outputs; the monitor pops and compares on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb;

   localparam int DW = 32;
   localparam int AW = 5;

   logic           clk;
   logic           rst_n;
   logic           we3;
   logic [AW-1:0]  a3;
   logic [DW-1:0]  wd3;
   logic [AW-1:0]  a1;
   logic [AW-1:0]  a2;
   logic [DW-1:0]  rd1;
   logic [DW-1:0]  rd2;
   logic           src1_used;
   logic           src2_used;
   logic           issue_valid;
   logic           issue_we;
   logic [AW-1:0]  issue_dst;
   logic           stall;
   logic [31:0]    busy_vec;

   typedef struct {
      string        name;
      bit           chk1;
      logic [31:0]  rd1;
      bit           chk2;
      logic [31:0]  rd2;
      logic         stall;
      logic [31:0]  busy;
   } exp_t;

   exp_t exp_q[$];
   int   tests;
   int   fails;

   regfile_wb #(.DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .we3         (we3),
      .a3          (a3),
      .wd3         (wd3),
      .a1          (a1),
      .a2          (a2),
      .rd1         (rd1),
      .rd2         (rd2),
      .src1_used   (src1_used),
      .src2_used   (src2_used),
      .issue_valid (issue_valid),
      .issue_we    (issue_we),
      .issue_dst   (issue_dst),
      .stall       (stall),
      .busy_vec    (busy_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // apply one input vector
   task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic s1, input logic s2,
                        input logic iv, input logic iw, input logic [4:0] dst);
      we3 = w; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2;
      src1_used = s1; src2_used = s2;
      issue_valid = iv; issue_we = iw; issue_dst = dst;
   endtask

   // queue the expected response for the vector just applied
   task automatic expect_out(input string n, input bit c1, input logic [31:0] r1,
                             input bit c2, input logic [31:0] r2,
                             input logic st, input logic [31:0] bv);
      exp_t e;
      e.name = n; e.chk1 = c1; e.rd1 = r1; e.chk2 = c2; e.rd2 = r2;
      e.stall = st; e.busy = bv;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // monitor: compare every queued expectation against the live outputs
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.chk1) begin
            tests++;
            if (rd1 !== e.rd1) begin
               fails++;
               $display("FAIL %s.rd1 actual=%h required=%h", e.name, rd1, e.rd1);
            end
         end
         if (e.chk2) begin
            tests++;
            if (rd2 !== e.rd2) begin
               fails++;
               $display("FAIL %s.rd2 actual=%h required=%h", e.name, rd2, e.rd2);
            end
         end
         tests++;
         if (stall !== e.stall) begin
            fails++;
            $display("FAIL %s.stall actual=%b required=%b", e.name, stall, e.stall);
         end
         tests++;
         if (busy_vec !== e.busy) begin
            fails++;
            $display("FAIL %s.busy actual=%h required=%h", e.name, busy_vec, e.busy);
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      drive(0, 0, 0, 5, 9, 1, 1, 0, 0, 0);
      #2;
      expect_out("reset_init", 1, 32'h0, 1, 32'h0, 0, 32'h0);
      #10 rst_n = 1'b1;

      // write with same-cycle bypass, then read back from storage
      next_cycle(); drive(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0);
      expect_out("wr_bypass", 1, 32'hDEADBEEF, 1, 32'h0, 0, 32'h0);
      next_cycle(); drive(0, 0, 0, 5, 5, 0, 0, 0, 0, 0);
      expect_out("wr_storage", 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0);

      // RAW: issue dst=7, consumer stalls until write-back to 7 arrives
      next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
      expect_out("issue7", 0, 0, 0, 0, 0, 32'h0);
      next_cycle(); drive(0, 0, 0, 7, 0, 1, 0, 1, 0, 0);
      expect_out("raw7_stall", 1, 32'h0, 0, 0, 1, 32'h0000_0080);
      next_cycle(); drive(1, 7, 32'd42, 7, 0, 1, 0, 1, 0, 0);
      expect_out("raw7_bypass", 1, 32'd42, 0, 0, 0, 32'h0000_0080);

      // clear of busy[7] observed; issue dst=3
      next_cycle(); drive(0, 0, 0, 7, 0, 0, 0, 1, 1, 3);
      expect_out("issue3", 1, 32'd42, 0, 0, 0, 32'h0);
      // busy source that is not used does not stall
      next_cycle(); drive(0, 0, 0, 0, 3, 1, 0, 1, 0, 0);
      expect_out("unused_src", 0, 0, 0, 0, 0, 32'h0000_0008);

      // WAW on register 9
      next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
      expect_out("issue9", 0, 0, 0, 0, 0, 32'h0000_0008);
      next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
      expect_out("waw_stall", 0, 0, 0, 0, 1, 32'h0000_0208);
      next_cycle();
      expect_out("waw_hold", 0, 0, 0, 0, 1, 32'h0000_0208);
      next_cycle(); drive(1, 9, 32'h99, 0, 0, 0, 0, 1, 1, 9);
      expect_out("waw_bypass", 0, 0, 0, 0, 0, 32'h0000_0208);
      next_cycle(); drive(0, 0, 0, 9, 0, 0, 0, 0, 0, 0);
      expect_out("waw_after", 1, 32'h99, 0, 0, 0, 32'h0000_0208);

      // set/clear collision on register 4
      next_cycle(); drive(1, 4, 32'h44, 0, 4, 0, 0, 1, 1, 4);
      expect_out("collide", 0, 0, 1, 32'h44, 0, 32'h0000_0208);
      next_cycle(); drive(0, 0, 0, 4, 9, 0, 0, 0, 0, 0);
      expect_out("collide_after", 1, 32'h44, 1, 32'h99, 0, 32'h0000_0218);

      // write-back to a different register does not mask RAW on src2
      next_cycle(); drive(1, 4, 32'h55, 0, 3, 0, 1, 1, 0, 0);
      expect_out("raw3_other_wb", 0, 0, 0, 0, 1, 32'h0000_0218);
      // no issue_valid, no stall
      next_cycle(); drive(0, 0, 0, 4, 3, 0, 1, 0, 0, 0);
      expect_out("no_issue", 1, 32'h55, 0, 0, 0, 32'h0000_0208);

      // asynchronous reset mid-operation, with a write in that cycle
      next_cycle(); drive(1, 6, 32'h66, 5, 9, 1, 1, 1, 1, 3);
      rst_n = 1'b0;
      expect_out("reset_mid", 1, 32'h0, 1, 32'h0, 0, 32'h0);
      next_cycle(); rst_n = 1'b1; drive(0, 0, 0, 6, 7, 0, 0, 0, 0, 0);
      expect_out("reset_after", 1, 32'h0, 1, 32'h0, 0, 32'h0);

      // let the monitor drain the queue, bounded
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
